vector_source: RTL and testbench
================================

# vector_source

Self-checking stimulus source for datapath component benches: generates a pseudo-random operand `a` and the matching expected result `dRef` (`a-1` or `a+1`), qualified by `valid`, and consumes the `err` line from the error monitor to tally mismatches. It drives the operand and reference at the DUT input and error monitor; the pass/fail summary comes back to it from the error monitor. It replaces free-running `$urandom` stimulus with a seeded, bounded, reproducible run that has start/done handshaking.

## Interface
- `DATAWIDTH`, 32, operand/result width; legal range 1..64
- `NUM_VECTORS`, 1000, vectors issued per run; 0 is legal
- `SEED`, 64'h1, LFSR seed; 0 is replaced by 1
- `DRAIN_CYCLES`, 2, cycles `err` is still sampled after the last vector
- `ERR_WIDTH`, 16, width of the error counter
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run; sampled in IDLE or DONE only
- `mode`  in  1  0: `dRef = a-1`; 1: `dRef = a+1`; sampled with `start`, held for the run
- `err`  in  1  mismatch flag from the error monitor
- `a`  out  DATAWIDTH  operand to the DUT
- `dRef`  out  DATAWIDTH  expected DUT result
- `valid`  out  1  `a`/`dRef` form a live vector
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  high in DONE
- `errCount`  out  ERR_WIDTH  mismatches seen in the current or last run

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- LFSR: 64-bit Galois, right shift. Next state = `(s>>1) ^ 64'hD800000000000000` if `s[0]`, else `s>>1`. It loads SEED (or 1) on reset and on each accepted `start`.
- Each vector is built from the current LFSR state, then the LFSR advances:
  - `a = s[DATAWIDTH-1:0]`
  - `dRef = a ∓ 1` modulo 2^DATAWIDTH, so wrap-around is silent: 0-1 = all-ones, all-ones+1 = 0.
- IDLE/DONE with `start=1` at an edge:
  - clear `errCount`, latch `mode`, reseed;
  - if NUM_VECTORS>0: emit vector 0 at that same edge, `valid=1`, go to RUN;
  - otherwise go to DRAIN.
- RUN: one new vector per cycle. After vector NUM_VECTORS-1 is emitted, go to DRAIN at the next edge and drop `valid`. `a`/`dRef` hold their last values.
- DRAIN: `valid=0`. Count DRAIN_CYCLES cycles, then go to DONE.
- DONE: `done=1`. Hold until `start` (new run) or `rst`.
- `start` in RUN/DRAIN is ignored. `mode` changes mid-run are ignored.
- `errCount` increments at each edge where `busy=1` and `err=1`. It saturates at all-ones and is never cleared except by `rst` or an accepted `start`.

## Timing
- Reset values (also after `rst` mid-run, which aborts immediately):
  - `a=0`, `dRef=0`, `valid=0`, `busy=0`, `done=0`, `errCount=0`
  - LFSR = seed; state IDLE.
- `a`, `dRef` and `valid` are registered and change on the same edge. `dRef` always corresponds to the `a` presented in the same cycle.
- Start latency: first `valid` in the cycle after the edge that samples `start`.
- `valid` is high for exactly NUM_VECTORS consecutive cycles per run.
- `busy` is high for NUM_VECTORS + DRAIN_CYCLES cycles. `done` rises on the edge `busy` falls.
- `start` held high continuously in DONE restarts a run on every DONE entry. In that case `done` is high for one cycle.

## Test plan
- SEED=1, DATAWIDTH=32, mode=0, NUM_VECTORS=2, start pulse:
  - vector 0: `a=32'h1`, `dRef=32'h0`;
  - vector 1: `a=32'h0`, `dRef=32'hFFFFFFFF`;
  - then `valid=0` for 2 cycles, then `done=1`.
- SEED=64'hFFFFFFFF, mode=1 -> `a=32'hFFFFFFFF`, `dRef=32'h0` (wrap). SEED=0 gives the same sequence as SEED=1.
- Run two starts back to back with the same SEED -> identical `a` sequences; `errCount` cleared at second start.
- Drive `err=1` for 3 cycles during RUN and 1 cycle in DRAIN -> `errCount=4` in DONE. Force 2^ERR_WIDTH+5 errors -> `errCount` stays all-ones.
- Assert `rst` at vector 500 of 1000 -> all outputs 0 next cycle. A new start reproduces vector 0 = SEED low bits.
- NUM_VECTORS=0 -> `valid` never rises; `busy` high 2 cycles, then `done=1`. `start` during RUN -> no effect on the vector count.

Source files
------------

// File: rtl/vector_source.sv
// Seeded stimulus source: emits operand a and expected result dRef = a-1 / a+1
// from a 64-bit Galois LFSR, runs with start/done handshaking and tallies err.
//   state   | meaning
//   S_IDLE  | waiting for start after reset
//   S_RUN   | one vector per cycle, valid high
//   S_DRAIN | valid low, err still sampled for DRAIN_CYCLES cycles
//   S_DONE  | run finished, done high until start or rst
module vector_source #(
  parameter int          DATAWIDTH    = 32,
  parameter int          NUM_VECTORS  = 1000,
  parameter logic [63:0] SEED         = 64'h1,
  parameter int          DRAIN_CYCLES = 2,
  parameter int          ERR_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 err,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] dRef,
  output logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic [ERR_WIDTH-1:0] errCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [63:0] SEED_EFF   = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam logic [63:0] TAPS       = 64'hD800000000000000;
  localparam logic [31:0] RUN_LOAD   = (NUM_VECTORS > 0) ? 32'(NUM_VECTORS - 1) : 32'h0;
  localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'h0;

  state_t                state, state_nxt;
  logic [31:0]           cnt, cnt_nxt;
  logic                  emit;
  logic                  accept;
  logic [63:0]           lfsr;
  logic [63:0]           vec_src;
  logic [63:0]           lfsr_adv;
  logic                  mode_q;
  logic                  mode_sel;
  logic [DATAWIDTH-1:0]  vec_a;
  logic [DATAWIDTH-1:0]  vec_ref;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt is a shared down-counter: remaining vectors in RUN, remaining cycles in DRAIN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    emit      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept = 1'b1;
          if (NUM_VECTORS > 0) begin
            state_nxt = S_RUN;
            cnt_nxt   = RUN_LOAD;
            emit      = 1'b1;
          end else if (DRAIN_CYCLES > 0) begin
            state_nxt = S_DRAIN;
            cnt_nxt   = DRAIN_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (cnt == 32'h0) begin
          if (DRAIN_CYCLES > 0) begin
            state_nxt = S_DRAIN;
            cnt_nxt   = DRAIN_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          cnt_nxt = cnt - 32'd1;
          emit    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == 32'h0) state_nxt = S_DONE;
        else              cnt_nxt   = cnt - 32'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // On an accepted start, vector 0 is built straight from the seed in the same cycle
  always_comb begin
    vec_src  = accept ? SEED_EFF : lfsr;
    mode_sel = accept ? mode : mode_q;
    vec_a    = vec_src[DATAWIDTH-1:0];
    vec_ref  = mode_sel ? (vec_a + DATAWIDTH'(1)) : (vec_a - DATAWIDTH'(1));
    lfsr_adv = vec_src[0] ? ((vec_src >> 1) ^ TAPS) : (vec_src >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a        <= '0;
      dRef     <= '0;
      valid    <= 1'b0;
      errCount <= '0;
      lfsr     <= SEED_EFF;
      mode_q   <= 1'b0;
    end else begin
      valid <= emit;
      if (accept) begin
        mode_q <= mode;
        lfsr   <= SEED_EFF;
      end
      if (emit) begin
        a    <= vec_a;
        dRef <= vec_ref;
        lfsr <= lfsr_adv;
      end
      if (accept)
        errCount <= '0;
      else if (busy && err && (errCount != '1))
        errCount <= errCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_source.sv
// Scoreboard bench for vector_source: stimulus queues expected vectors and
// status checks, a negedge monitor pops and compares them.
module tb_vector_source;

  localparam int NI = 5;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s [NI];
  logic        mode_s  [NI];
  logic        err_s   [NI];
  logic [31:0] a_s     [NI];
  logic [31:0] dref_s  [NI];
  logic        valid_s [NI];
  logic        busy_s  [NI];
  logic        done_s  [NI];
  logic [15:0] ec_s    [NI];
  logic [2:0]  ec_b;

  logic [63:0] exp_q [NI][$];
  chk_t        chk_q [$];
  int          vcnt  [NI];
  int          bcnt  [NI];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // 0: seed 1, 2 vectors; 1: seed 0; 2: seed FFFFFFFF; 3: 1000 vectors, 3-bit errCount; 4: no vectors
  vector_source #(.DATAWIDTH(32), .NUM_VECTORS(2), .SEED(64'h1), .DRAIN_CYCLES(2), .ERR_WIDTH(16)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .mode(mode_s[0]), .err(err_s[0]), .a(a_s[0]),
    .dRef(dref_s[0]), .valid(valid_s[0]), .busy(busy_s[0]), .done(done_s[0]), .errCount(ec_s[0]));
  vector_source #(.DATAWIDTH(32), .NUM_VECTORS(2), .SEED(64'h0), .DRAIN_CYCLES(2), .ERR_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .mode(mode_s[1]), .err(err_s[1]), .a(a_s[1]),
    .dRef(dref_s[1]), .valid(valid_s[1]), .busy(busy_s[1]), .done(done_s[1]), .errCount(ec_s[1]));
  vector_source #(.DATAWIDTH(32), .NUM_VECTORS(2), .SEED(64'hFFFFFFFF), .DRAIN_CYCLES(2), .ERR_WIDTH(16)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .mode(mode_s[2]), .err(err_s[2]), .a(a_s[2]),
    .dRef(dref_s[2]), .valid(valid_s[2]), .busy(busy_s[2]), .done(done_s[2]), .errCount(ec_s[2]));
  vector_source #(.DATAWIDTH(32), .NUM_VECTORS(1000), .SEED(64'h1), .DRAIN_CYCLES(2), .ERR_WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .start(start_s[3]), .mode(mode_s[3]), .err(err_s[3]), .a(a_s[3]),
    .dRef(dref_s[3]), .valid(valid_s[3]), .busy(busy_s[3]), .done(done_s[3]), .errCount(ec_b));
  vector_source #(.DATAWIDTH(32), .NUM_VECTORS(0), .SEED(64'h1), .DRAIN_CYCLES(2), .ERR_WIDTH(16)) u4 (
    .clk(clk), .rst(rst), .start(start_s[4]), .mode(mode_s[4]), .err(err_s[4]), .a(a_s[4]),
    .dRef(dref_s[4]), .valid(valid_s[4]), .busy(busy_s[4]), .done(done_s[4]), .errCount(ec_s[4]));

  assign ec_s[3] = {13'h0, ec_b};

  function automatic logic [63:0] lfsr_step(logic [63:0] s);
    return s[0] ? ((s >> 1) ^ 64'hD800000000000000) : (s >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic push_vec(int idx, logic [31:0] av, logic [31:0] rv);
    exp_q[idx].push_back({av, rv});
  endtask

  task automatic push_run(int idx, logic [63:0] seed, logic md, int n);
    logic [63:0] s;
    logic [31:0] av;
    s = seed;
    for (int k = 0; k < n; k++) begin
      av = s[31:0];
      push_vec(idx, av, md ? av + 32'd1 : av - 32'd1);
      s = lfsr_step(s);
    end
  endtask

  task automatic wait_done(int idx, int budget);
    int n;
    n = 0;
    while (!done_s[idx] && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("done_reached%0d", idx), {63'h0, done_s[idx]}, 64'h1);
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    chk_t        c;
    for (int i = 0; i < NI; i++) begin
      if (valid_s[i]) begin
        vcnt[i]++;
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL vec%0d unexpected valid: a=%h dRef=%h, no vector required", i, a_s[i], dref_s[i]);
        end else begin
          e = exp_q[i].pop_front();
          if ({a_s[i], dref_s[i]} !== e) begin
            errors++;
            $display("FAIL vec%0d got a=%h dRef=%h, required a=%h dRef=%h",
                     i, a_s[i], dref_s[i], e[63:32], e[31:0]);
          end
        end
      end
      if (busy_s[i]) bcnt[i]++;
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s got %0h, required %0h", c.name, c.act, c.exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, b0;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0;
      mode_s[i]  = 1'b0;
      err_s[i]   = 1'b0;
      vcnt[i]    = 0;
      bcnt[i]    = 0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a", {32'h0, a_s[0]}, 64'h0);
    chk("rst_dref", {32'h0, dref_s[0]}, 64'h0);
    chk("rst_flags", {61'h0, valid_s[0], busy_s[0], done_s[0]}, 64'h0);
    chk("rst_errcount", {48'h0, ec_s[0]}, 64'h0);

    // Short runs: hold start on u0 to get a back-to-back restart
    push_vec(0, 32'h1, 32'h0);
    push_vec(0, 32'h0, 32'hFFFFFFFF);
    push_vec(0, 32'h1, 32'h0);
    push_vec(0, 32'h0, 32'hFFFFFFFF);
    push_vec(1, 32'h1, 32'h0);
    push_vec(1, 32'h0, 32'hFFFFFFFF);
    push_vec(2, 32'hFFFFFFFF, 32'h0);
    push_vec(2, 32'h7FFFFFFF, 32'h80000000);
    start_s[0] = 1'b1;
    start_s[1] = 1'b1;
    start_s[2] = 1'b1;
    mode_s[2]  = 1'b1;
    start_s[4] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    start_s[2] = 1'b0;
    mode_s[2]  = 1'b0;
    start_s[4] = 1'b0;
    err_s[0]   = 1'b1;
    chk("t0_flags", {61'h0, valid_s[0], busy_s[0], done_s[0]}, 64'h6);
    chk("nv0_t0_flags", {61'h0, valid_s[4], busy_s[4], done_s[4]}, 64'h2);
    tick();
    chk("t1_flags", {61'h0, valid_s[0], busy_s[0], done_s[0]}, 64'h6);
    chk("nv0_t1_flags", {61'h0, valid_s[4], busy_s[4], done_s[4]}, 64'h2);
    tick();
    err_s[0] = 1'b0;
    chk("t2_flags", {61'h0, valid_s[0], busy_s[0], done_s[0]}, 64'h2);
    chk("t2_errcount", {48'h0, ec_s[0]}, 64'h2);
    chk("nv0_t2_flags", {61'h0, valid_s[4], busy_s[4], done_s[4]}, 64'h1);
    tick();
    chk("t3_flags", {61'h0, valid_s[0], busy_s[0], done_s[0]}, 64'h2);
    tick();
    chk("t4_flags", {61'h0, valid_s[0], busy_s[0], done_s[0]}, 64'h1);
    chk("t4_errcount", {48'h0, ec_s[0]}, 64'h2);
    chk("seed0_done", {63'h0, done_s[1]}, 64'h1);
    chk("wrap_done", {63'h0, done_s[2]}, 64'h1);
    tick();
    start_s[0] = 1'b0;
    chk("restart_flags", {61'h0, valid_s[0], busy_s[0], done_s[0]}, 64'h6);
    chk("restart_errclr", {48'h0, ec_s[0]}, 64'h0);
    wait_done(0, 20);
    chk("short_vcount", vcnt[0], 64'd4);
    chk("short_busy", bcnt[0], 64'd8);
    chk("nv0_vcount", vcnt[4], 64'd0);
    chk("nv0_busy", bcnt[4], 64'd2);

    // Long run 1: 3 errors in RUN, 1 in DRAIN
    v0 = vcnt[3];
    b0 = bcnt[3];
    push_run(3, 64'h1, 1'b0, 1000);
    start_s[3] = 1'b1;
    tick();
    start_s[3] = 1'b0;
    repeat (10) tick();
    err_s[3] = 1'b1;
    repeat (3) tick();
    err_s[3] = 1'b0;
    for (int n = 0; n < 1100 && valid_s[3]; n++) tick();
    chk("drain_entry", {62'h0, valid_s[3], busy_s[3]}, 64'h1);
    err_s[3] = 1'b1;
    tick();
    err_s[3] = 1'b0;
    wait_done(3, 10);
    chk("run1_errcount", {48'h0, ec_s[3]}, 64'd4);
    chk("run1_vcount", vcnt[3] - v0, 64'd1000);
    chk("run1_busy", bcnt[3] - b0, 64'd1002);

    // Long run 2: saturate errCount, then reset at vector 500
    v0 = vcnt[3];
    push_run(3, 64'h1, 1'b1, 500);
    mode_s[3]  = 1'b1;
    start_s[3] = 1'b1;
    tick();
    start_s[3] = 1'b0;
    mode_s[3]  = 1'b0;
    chk("run2_errclr", {48'h0, ec_s[3]}, 64'h0);
    err_s[3] = 1'b1;
    repeat (13) tick();
    err_s[3] = 1'b0;
    chk("errcount_sat", {48'h0, ec_s[3]}, 64'd7);
    repeat (486) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_a", {32'h0, a_s[3]}, 64'h0);
    chk("midrst_dref", {32'h0, dref_s[3]}, 64'h0);
    chk("midrst_flags", {61'h0, valid_s[3], busy_s[3], done_s[3]}, 64'h0);
    chk("midrst_errcount", {48'h0, ec_s[3]}, 64'h0);
    chk("run2_vcount", vcnt[3] - v0, 64'd500);

    // Long run 3: start pulse mid-run must not change the vector count
    v0 = vcnt[3];
    push_run(3, 64'h1, 1'b0, 1000);
    start_s[3] = 1'b1;
    tick();
    start_s[3] = 1'b0;
    repeat (100) tick();
    start_s[3] = 1'b1;
    tick();
    start_s[3] = 1'b0;
    wait_done(3, 1100);
    chk("run3_vcount", vcnt[3] - v0, 64'd1000);
    chk("run3_errcount", {48'h0, ec_s[3]}, 64'h0);

    tick();
    for (int i = 0; i < NI; i++) chk($sformatf("queue_empty%0d", i), exp_q[i].size(), 64'h0);
    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
